// File: rtl/window_gen_3x3_if.sv
// window_gen_3x3_if: column-in / window-out stream bundle for the 3x3 window generator
interface window_gen_3x3_if #(
   parameter int WIDTH = 8,
   parameter int IMG_WIDTH = 6,
   parameter int IMG_HEIGHT = 6
);
   logic valid_in;
   logic [WIDTH-1:0] row0_din;
   logic [WIDTH-1:0] row1_din;
   logic [WIDTH-1:0] row2_din;
   logic valid_out;
   logic [9*WIDTH-1:0] win_dout;
   logic [$clog2(IMG_WIDTH)-1:0] ctr_col;
   logic [$clog2(IMG_HEIGHT)-1:0] ctr_row;
   logic frame_done;
   modport master (
      output valid_in, row0_din, row1_din, row2_din,
      input valid_out, win_dout, ctr_col, ctr_row, frame_done
   );
   modport slave (
      input valid_in, row0_din, row1_din, row2_din,
      output valid_out, win_dout, ctr_col, ctr_row, frame_done
   );
endinterface

// File: rtl/window_gen_3x3.sv
// window_gen_3x3: shifts aligned pixel columns into a 3x3 window and emits complete windows with centre coordinates
module window_gen_3x3 #(
   parameter int WIDTH = 8,
   parameter int IMG_WIDTH = 6,
   parameter int IMG_HEIGHT = 6
) (
   input logic clock,
   input logic reset,
   window_gen_3x3_if.slave bus
);
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] col_last = CW'(IMG_WIDTH - 1);
   localparam logic [CW-1:0] col_one = CW'(1);
   localparam logic [RW-1:0] row_last = RW'(IMG_HEIGHT - 3);
   typedef enum logic {FILL, RUN} state_t;
   state_t state;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [1:0][WIDTH-1:0] top_q, mid_q, bot_q;
   logic [9*WIDTH-1:0] win_next;
   logic col_end, row_end, emit;
   assign col_end = col == col_last;
   assign row_end = row == row_last;
   assign emit = bus.valid_in && state == RUN;
   // only the two older columns are stored; the incoming column is the right edge
   assign win_next = {bus.row0_din, bot_q, bus.row1_din, mid_q, bus.row2_din, top_q};
   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= FILL;
         col <= '0;
         row <= '0;
         top_q <= '0;
         mid_q <= '0;
         bot_q <= '0;
         bus.valid_out <= 1'b0;
         bus.frame_done <= 1'b0;
         bus.win_dout <= '0;
         bus.ctr_col <= '0;
         bus.ctr_row <= '0;
      end else begin
         bus.valid_out <= emit;
         bus.frame_done <= emit && col_end && row_end;
         if (bus.valid_in) begin
            top_q <= {bus.row2_din, top_q[1]};
            mid_q <= {bus.row1_din, mid_q[1]};
            bot_q <= {bus.row0_din, bot_q[1]};
            col <= col_end ? '0 : col + 1'b1;
            row <= col_end ? (row_end ? '0 : row + 1'b1) : row;
            state <= col_end ? FILL : (col == col_one ? RUN : state);
            if (state == RUN) begin
               bus.win_dout <= win_next;
               bus.ctr_col <= col - 1'b1;
               bus.ctr_row <= row + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_window_gen_3x3.sv
// tb_window_gen_3x3: scoreboard bench comparing streamed windows against windows cut directly from a stored image
module tb_window_gen_3x3;
   localparam int W = 8, IW = 6, IH = 6;
   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;
   window_gen_3x3_if #(.WIDTH(W), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)) bus();
   window_gen_3x3 #(.WIDTH(W), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus.slave)
   );
   typedef struct {
      logic [9*W-1:0] win;
      logic [2:0] cc;
      logic [2:0] cr;
      logic fd;
   } exp_t;
   exp_t exp_q[$];
   int checks = 0, errors = 0, n_vo = 0, n_fd = 0, v0 = 0, f0 = 0;
   logic [W-1:0] img [IH][IW];
   logic [9*W-1:0] last_win = '0;
   logic vin_q;
   task automatic chk(string name, logic [71:0] act, logic [71:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask
   task automatic fill_img(bit pattern);
      for (int r = 0; r < IH; r++)
         for (int c = 0; c < IW; c++)
            img[r][c] = pattern ? W'(16 * r + c) : W'($urandom);
   endtask
   task automatic send(int r, int c, bit push);
      exp_t e;
      bus.valid_in = 1'b1;
      bus.row0_din = img[r][c];
      bus.row1_din = img[r-1][c];
      bus.row2_din = img[r-2][c];
      if (push && c >= 2) begin
         e.win = '0;
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
               e.win[(3*i+j)*W +: W] = img[r-2+i][c-2+j];
         e.cc = 3'(c - 1);
         e.cr = 3'(r - 1);
         e.fd = (r == IH - 1) && (c == IW - 1);
         exp_q.push_back(e);
      end
      @(negedge clock);
   endtask
   task automatic idle();
      bus.valid_in = 1'b0;
      @(negedge clock);
   endtask
   task automatic frame(bit bub);
      for (int r = 2; r < IH; r++)
         for (int c = 0; c < IW; c++) begin
            if (bub) while ($urandom_range(1, 0) == 1) idle();
            send(r, c, 1'b1);
         end
   endtask
   task automatic chk_zero(string tag);
      chk({tag, "_vo"}, 72'(bus.valid_out), 72'(0));
      chk({tag, "_fd"}, 72'(bus.frame_done), 72'(0));
      chk({tag, "_win"}, 72'(bus.win_dout), 72'(0));
      chk({tag, "_col"}, 72'(bus.ctr_col), 72'(0));
      chk({tag, "_row"}, 72'(bus.ctr_row), 72'(0));
   endtask
   always @(posedge clock) begin
      exp_t e;
      vin_q = bus.valid_in;
      #1;
      if (!vin_q) chk("vo_after_idle", 72'(bus.valid_out), 72'(0));
      if (bus.frame_done && !bus.valid_out) chk("fd_without_vo", 72'(1), 72'(0));
      if (bus.valid_out) begin
         n_vo++;
         if (bus.frame_done) n_fd++;
         last_win = bus.win_dout;
         if (exp_q.size() == 0) chk("unexpected_window", 72'(bus.win_dout), 72'(0) - 72'(1));
         else begin
            e = exp_q.pop_front();
            chk("win", 72'(bus.win_dout), 72'(e.win));
            chk("ctr_col", 72'(bus.ctr_col), 72'(e.cc));
            chk("ctr_row", 72'(bus.ctr_row), 72'(e.cr));
            chk("frame_done", 72'(bus.frame_done), 72'(e.fd));
         end
      end
   end
   initial begin
      bus.valid_in = 1'b0;
      bus.row0_din = '0;
      bus.row1_din = '0;
      bus.row2_din = '0;
      repeat (2) @(negedge clock);
      chk_zero("reset");
      reset = 1'b1;
      fill_img(1'b1);
      v0 = n_vo;
      f0 = n_fd;
      send(2, 0, 1'b1);
      send(2, 1, 1'b1);
      send(2, 2, 1'b1);
      chk("first_vo", 72'(bus.valid_out), 72'(1));
      chk("first_win", 72'(bus.win_dout), 72'h22_21_20_12_11_10_02_01_00);
      chk("first_col", 72'(bus.ctr_col), 72'(1));
      chk("first_row", 72'(bus.ctr_row), 72'(1));
      for (int c = 3; c < IW; c++) send(2, c, 1'b1);
      for (int r = 3; r < IH; r++)
         for (int c = 0; c < IW; c++) send(r, c, 1'b1);
      idle();
      chk("full_windows", 72'(n_vo - v0), 72'(16));
      chk("full_fd", 72'(n_fd - f0), 72'(1));
      chk("last_centre", 72'(last_win[4*W +: W]), 72'(8'h44));
      fill_img(1'b0);
      v0 = n_vo;
      f0 = n_fd;
      frame(1'b1);
      idle();
      chk("bubble_windows", 72'(n_vo - v0), 72'(16));
      chk("bubble_fd", 72'(n_fd - f0), 72'(1));
      fill_img(1'b1);
      for (int k = 0; k < 10; k++) send(2 + k / IW, k % IW, 1'b1);
      reset = 1'b0;
      send(3, 4, 1'b0);
      reset = 1'b1;
      bus.valid_in = 1'b0;
      chk_zero("midreset");
      fill_img(1'b1);
      v0 = n_vo;
      f0 = n_fd;
      frame(1'b0);
      idle();
      chk("restart_windows", 72'(n_vo - v0), 72'(16));
      chk("restart_fd", 72'(n_fd - f0), 72'(1));
      fill_img(1'b0);
      v0 = n_vo;
      f0 = n_fd;
      frame(1'b0);
      fill_img(1'b0);
      frame(1'b0);
      idle();
      chk("b2b_windows", 72'(n_vo - v0), 72'(32));
      chk("b2b_fd", 72'(n_fd - f0), 72'(2));
      repeat (2) idle();
      chk("drained", 72'(exp_q.size()), 72'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/window_gen_3x3.md
# window_gen_3x3

Streaming 3x3 sliding-window assembler and the consumer of the cascaded line buffers in the image pipeline. Each cycle with `valid_in` it takes one column of three vertically aligned pixels: the live pixel, the one-line-delayed pixel and the two-line-delayed pixel. It shifts that column into a 3x3 register window and emits a complete window, with centre-pixel coordinates, once three columns of the current row have arrived. Downstream 3x3 kernels (filter, edge detect) read its output directly.

## Interface
- `WIDTH`, default 8: pixel width in bits.
- `IMG_WIDTH`, default 6: pixels per line; minimum 3.
- `IMG_HEIGHT`, default 6: lines per frame; minimum 3.
- `clock` input, 1 bit: single clock; all logic is on the rising edge.
- `reset` input, 1 bit: synchronous, active-low. Sampled at the rising edge of `clock`; 0 resets.
- `valid_in` input, 1 bit: the three row inputs are valid and aligned this cycle. Driven from the second line buffer's `valid_out`.
- `row0_din` input, `WIDTH` bits: newest line (bottom row of window).
- `row1_din` input, `WIDTH` bits: one line older (middle row).
- `row2_din` input, `WIDTH` bits: two lines older (top row).
- `valid_out` output, 1 bit: `win_dout` holds a complete window.
- `win_dout` output, `9*WIDTH` bits: pixel (r,c) is at `win_dout[(3*r+c)*WIDTH +: WIDTH]`. r=0 is the top row and c=0 is the leftmost (oldest) column, so index 4 is the centre.
- `ctr_col` output, `$clog2(IMG_WIDTH)` bits: image column of the centre pixel; valid with `valid_out`.
- `ctr_row` output, `$clog2(IMG_HEIGHT)` bits: image row of the centre pixel; valid with `valid_out`.
- `frame_done` output, 1 bit: one-cycle pulse after the last window of a frame.

## Operation
- The window is 9 registers. On an accepted input (`valid_in`=1), columns shift left: c0<-c1, c1<-c2, c2<-{row2_din, row1_din, row0_din}.
- With `valid_in`=0, all state holds: window, counters and FSM.
- `col` counter runs 0..IMG_WIDTH-1 and holds the column index of the next accepted input.
  - Increments on each accepted input.
  - At IMG_WIDTH-1 it wraps to 0 and `row` increments.
- `row` counter runs 0..IMG_HEIGHT-3 and counts line triplets within a frame.
  - Accepted input with col=IMG_WIDTH-1 and row=IMG_HEIGHT-3: row wraps to 0.
- FSM states:
  - FILL: the first two inputs of a line. Window is incomplete, no output. Goes to RUN when an input is accepted with col=1.
  - RUN: every accepted input produces a window. Goes to FILL when an input is accepted with col=IMG_WIDTH-1.
- Windows never straddle two lines. The wrap to FILL discards the stale left columns logically; they are overwritten before the next output.
- Output on an accepted input in RUN:
  - `valid_out`=1 next cycle.
  - `ctr_col` = col-1 (col being the accepted input's index).
  - `ctr_row` = row+1.
- Outputs per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows. Border pixels get no centred window; padding is the kernel's responsibility.
- `frame_done`=1 for one cycle, coincident with the final window's `valid_out`.
- `reset`=0 mid-frame aborts the frame. The next accepted input is treated as col 0, row 0.

## Timing
- Latency: 1 cycle from the accepted input to `valid_out`, `win_dout`, `ctr_*` and `frame_done`. All are registered.
- `valid_out` is a single-cycle qualifier. It is low on any cycle following `valid_in`=0 or a FILL-state input.
- `win_dout` and `ctr_*` hold their last values while `valid_out`=0. Consumers must qualify with `valid_out`.
- Back-to-back `valid_in` gives one window per cycle in RUN. There is no backpressure.
- Values on reset (`reset`=0 at a rising edge):
  - `valid_out`=0, `frame_done`=0.
  - `win_dout`=0, `ctr_col`=0, `ctr_row`=0.
  - `col`=0, `row`=0, FSM=FILL.
- Reset has priority over a simultaneous `valid_in`; that input is dropped.
- Bubbles (`valid_in` low for any number of cycles, including across a line boundary) must not alter the result.

## Test plan
Common setup: IMG_WIDTH=6, IMG_HEIGHT=6, WIDTH=8. Source pixel p(r,c)=16r+c. Stream rows 2..5 as row0=p(r,c), row1=p(r-1,c), row2=p(r-2,c).

- First window: feed 3 inputs of line r=2 back-to-back. Require `valid_out`=1 only on the cycle after the 3rd input; `win_dout` indices 0..8 = 00,01,02,10,11,12,20,21,22; `ctr_col`=1, `ctr_row`=1.
- Full frame, continuous `valid_in` for 24 inputs: exactly 16 `valid_out` pulses. Last window centre is (4,4) = 0x44. `frame_done`=1 only with that window.
- Line wrap: after input (2,5), the inputs (3,0) and (3,1) produce no output. Input (3,2) yields a window with index0=0x10 and `ctr_row`=2.
- Random bubbles: `valid_in` de-asserted 50% of cycles, including between lines. Require window sequence and coordinates identical to the continuous run, and `valid_out` never asserted on a cycle following `valid_in`=0.
- Reset mid-frame: assert `reset`=0 after 10 inputs, together with `valid_in`=1. Require all outputs 0 next cycle. The restarted frame then gives the same 16 windows as the full-frame case.
- Back-to-back frames: two 24-input frames with no gap. Require 32 windows, two `frame_done` pulses, and second-frame `ctr_row` restarting at 1.
